// File: rtl/switch_mcu_pkg.sv
// rtl/switch_mcu_pkg.sv - shared AHB codes and instruction-memory state encoding
package switch_mcu_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [3:0] HSIZE_WORD = 4'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_READY = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ERR1  = 3'd3,
        ST_ERR2  = 3'd4
    } imem_state_e;

endpackage

// File: rtl/switch_mcu_imem_ram.sv
// rtl/switch_mcu_imem_ram.sv - single-port synchronous RAM with registered read data
module switch_mcu_imem_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          in_clk,
    input  logic          in_we,
    input  logic [AW-1:0] in_addr,
    input  logic [31:0]   in_wdata,
    output logic [31:0]   out_rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Contents are deliberately not reset; the owner gates unloaded words.
    always_ff @(posedge in_clk) begin
        if (in_we) begin
            mem_q[in_addr] <= in_wdata;
        end
        rdata_q <= mem_q[in_addr];
    end

    assign out_rdata = rdata_q;

endmodule

// File: rtl/switch_mcu_imem.sv
// rtl/switch_mcu_imem.sv - boot-loaded instruction memory serving AHB word fetches
module switch_mcu_imem
    import switch_mcu_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_ld_valid,
    input  logic [31:0] in_ld_data,
    input  logic        in_ld_last,
    output logic        out_ld_ready,
    output logic        out_init_done,
    input  logic        in_hsel,
    input  logic [31:0] in_haddr,
    input  logic [1:0]  in_htrans,
    input  logic        in_hwrite,
    input  logic [3:0]  in_hsize,
    input  logic        in_hreadyin,
    output logic        out_hready,
    output logic        out_hresp,
    output logic [31:0] out_hrdata
);

    localparam int AW = $clog2(DEPTH_WORDS);

    imem_state_e   state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   loaded_q, loaded_d;
    logic [2:0]    wait_q, wait_d;
    logic          done_q, done_d;
    logic          ld_ready_q, ld_ready_d;

    logic          hready, hresp;
    logic [31:0]   hrdata;
    logic          ld_fire, accept, xfer_err;
    logic          ram_we;
    logic [AW-1:0] ram_addr, haddr_idx;
    logic [31:0]   ram_rdata;

    assign haddr_idx = in_haddr[AW+1:2];

    always_comb begin
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        hrdata = '0;
        case (state_q)
            ST_WAIT: begin
                if (wait_q != 3'd0) begin
                    hready = 1'b0;
                end else if ({1'b0, idx_q} < loaded_q) begin
                    hrdata = ram_rdata;
                end
            end
            ST_ERR1: begin
                hready = 1'b0;
                hresp  = HRESP_ERROR;
            end
            ST_ERR2: begin
                hresp = HRESP_ERROR;
            end
            default: ;
        endcase
    end

    assign accept   = in_hsel && (in_htrans != HTRANS_IDLE) && in_hreadyin && hready;
    // done_q is low in LOAD and in an error response that started in LOAD.
    assign xfer_err = !done_q || in_hwrite || (in_hsize != HSIZE_WORD)
                      || (in_haddr[1:0] != 2'b00) || (in_haddr[31:2] >= 30'(DEPTH_WORDS));
    assign ld_fire  = (state_q == ST_LOAD) && ld_ready_q && in_ld_valid;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        idx_d    = idx_q;
        loaded_d = loaded_q;
        wait_d   = wait_q;
        done_d   = done_q;
        ram_we   = ld_fire;

        if (ld_fire) begin
            if (in_ld_last || (wr_ptr_q == AW'(DEPTH_WORDS - 1))) begin
                loaded_d = {1'b0, wr_ptr_q} + {{AW{1'b0}}, 1'b1};
                done_d   = 1'b1;
                state_d  = ST_READY;
            end else begin
                wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end
        end

        case (state_q)
            ST_WAIT: begin
                if (wait_q != 3'd0) begin
                    wait_d = wait_q - 3'd1;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = done_q ? ST_READY : ST_LOAD;
            default: ;
        endcase

        // A transfer accepted in a final response cycle overrides the return to idle.
        if (accept) begin
            if (xfer_err) begin
                state_d = ST_ERR1;
            end else begin
                state_d = ST_WAIT;
                idx_d   = haddr_idx;
                wait_d  = 3'(WAIT_STATES);
            end
        end

        ld_ready_d = (state_d == ST_LOAD);
    end

    // Presenting the incoming index on the accept cycle makes data ready even with zero waits.
    assign ram_addr = (state_q == ST_LOAD) ? wr_ptr_q : (accept ? haddr_idx : idx_q);

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q    <= ST_LOAD;
            wr_ptr_q   <= '0;
            idx_q      <= '0;
            loaded_q   <= '0;
            wait_q     <= '0;
            done_q     <= 1'b0;
            ld_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            idx_q      <= idx_d;
            loaded_q   <= loaded_d;
            wait_q     <= wait_d;
            done_q     <= done_d;
            ld_ready_q <= ld_ready_d;
        end
    end

    switch_mcu_imem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .in_clk   (in_clk),
        .in_we    (ram_we),
        .in_addr  (ram_addr),
        .in_wdata (in_ld_data),
        .out_rdata(ram_rdata)
    );

    assign out_ld_ready  = ld_ready_q;
    assign out_init_done = done_q;
    assign out_hready    = hready;
    assign out_hresp     = hresp;
    assign out_hrdata    = hrdata;

endmodule

// File: tb/tb_switch_mcu_imem.sv
// tb/tb_switch_mcu_imem.sv - self-checking bench for switch_mcu_imem
module tb_switch_mcu_imem;
    import switch_mcu_pkg::*;

    localparam int DEPTH = 256;
    localparam int WS    = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid, ld_last, ld_ready, init_done;
    logic [31:0] ld_data;
    logic        hsel, hwrite, hreadyin, hready, hresp;
    logic [31:0] haddr, hrdata;
    logic [1:0]  htrans;
    logic [3:0]  hsize;

    always #5 clk = ~clk;

    switch_mcu_imem #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .in_clk       (clk),
        .in_rst       (rst),
        .in_ld_valid  (ld_valid),
        .in_ld_data   (ld_data),
        .in_ld_last   (ld_last),
        .out_ld_ready (ld_ready),
        .out_init_done(init_done),
        .in_hsel      (hsel),
        .in_haddr     (haddr),
        .in_htrans    (htrans),
        .in_hwrite    (hwrite),
        .in_hsize     (hsize),
        .in_hreadyin  (hreadyin),
        .out_hready   (hready),
        .out_hresp    (hresp),
        .out_hrdata   (hrdata)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [DEPTH];
    int          model_loaded;
    bit          model_done;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  size;
        logic [1:0]  trans;
        logic        rdyin;
        logic        exp_acc;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus;
        hsel     = 1'b0;
        htrans   = HTRANS_IDLE;
        hwrite   = 1'b0;
        hsize    = HSIZE_WORD;
        haddr    = '0;
        hreadyin = 1'b1;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        idle_bus();
        #1;
        chk("rst_hready", hready, 1);
        chk("rst_hresp", hresp, 0);
        chk("rst_hrdata", hrdata, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_ld_ready", ld_ready, 0);
        tick();
        rst          = 1'b0;
        model_loaded = 0;
        model_done   = 1'b0;
        chk("rel_ld_ready_low", ld_ready, 0);
        tick();
        chk("rel_ld_ready_high", ld_ready, 1);
    endtask

    task automatic load_words(input int n, input bit use_last, input bit gaps, input bit fixed);
        int          k = 0;
        int          guard = 0;
        logic [31:0] d;
        bit          hs;
        while (k < n && guard < 4 * DEPTH + 50) begin
            chk("init_done_in_load", init_done, 0);
            d        = fixed ? 32'(k + 1) * 32'h11 : $urandom;
            ld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            ld_data  = d;
            ld_last  = use_last && (k == n - 1);
            hs       = ld_valid && ld_ready;
            tick();
            guard++;
            if (hs) begin
                model_mem[k] = d;
                k++;
            end
        end
        ld_valid     = 1'b0;
        ld_last      = 1'b0;
        model_loaded = k;
        model_done   = 1'b1;
        chk("load_count", k, n);
        chk("init_done_after_load", init_done, 1);
        chk("ld_ready_after_load", ld_ready, 0);
    endtask

    task automatic predict(input logic [31:0] addr, input logic wr, input logic [3:0] size,
                           input logic [1:0] trans, input logic rdyin,
                           output logic acc, output logic err, output logic [31:0] data);
        int idx = int'(addr >> 2);
        acc  = rdyin && (trans != 2'b00);
        err  = !model_done || wr || (size != 4'd2) || (addr[1:0] != 2'b00) || (idx >= DEPTH);
        data = '0;
        if (acc && !err && idx < model_loaded) begin
            data = model_mem[idx];
        end
    endtask

    task automatic xfer(input string name, input logic [31:0] addr, input logic wr,
                        input logic [3:0] size, input logic [1:0] trans, input logic rdyin,
                        input logic exp_acc, input logic exp_err, input logic [31:0] exp_data);
        int waits = 0;
        chk({name, "_ready_before"}, hready, 1);
        hsel     = 1'b1;
        haddr    = addr;
        hwrite   = wr;
        hsize    = size;
        htrans   = trans;
        hreadyin = rdyin;
        tick();
        idle_bus();
        if (!exp_acc) begin
            chk({name, "_noacc_hready"}, hready, 1);
            chk({name, "_noacc_hresp"}, hresp, 0);
            chk({name, "_noacc_hrdata"}, hrdata, 0);
        end else begin
            while (hready !== 1'b1 && waits < 20) begin
                chk({name, "_stall_hrdata"}, hrdata, 0);
                chk({name, "_stall_hresp"}, hresp, exp_err);
                waits++;
                tick();
            end
            chk({name, "_hready"}, hready, 1);
            chk({name, "_waits"}, waits, exp_err ? 1 : WS);
            chk({name, "_hresp"}, hresp, exp_err);
            chk({name, "_hrdata"}, hrdata, exp_data);
            tick();
            chk({name, "_after_hready"}, hready, 1);
            chk({name, "_after_hresp"}, hresp, 0);
            chk({name, "_after_hrdata"}, hrdata, 0);
        end
        chk({name, "_init_done"}, init_done, model_done);
        chk({name, "_ld_ready"}, ld_ready, !model_done);
    endtask

    initial begin
        logic        acc, err;
        logic [31:0] data, a;
        logic        wr, rdy;
        logic [3:0]  sz;
        logic [1:0]  tr;

        vecs[0]  = '{32'h0,   1'b0, 4'd2, 2'b10, 1'b1, 1'b1, 1'b0, 32'h11};
        vecs[1]  = '{32'hC,   1'b0, 4'd2, 2'b10, 1'b1, 1'b1, 1'b0, 32'h44};
        vecs[2]  = '{32'h10,  1'b0, 4'd2, 2'b10, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{32'h400, 1'b0, 4'd2, 2'b10, 1'b1, 1'b1, 1'b1, 32'h0};
        vecs[4]  = '{32'h0,   1'b1, 4'd2, 2'b10, 1'b1, 1'b1, 1'b1, 32'h0};
        vecs[5]  = '{32'h0,   1'b0, 4'd0, 2'b10, 1'b1, 1'b1, 1'b1, 32'h0};
        vecs[6]  = '{32'h2,   1'b0, 4'd2, 2'b10, 1'b1, 1'b1, 1'b1, 32'h0};
        vecs[7]  = '{32'h4,   1'b0, 4'd2, 2'b01, 1'b1, 1'b1, 1'b0, 32'h22};
        vecs[8]  = '{32'h8,   1'b0, 4'd2, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{32'h8,   1'b0, 4'd2, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{32'h8,   1'b0, 4'd2, 2'b11, 1'b1, 1'b1, 1'b0, 32'h33};
        vecs[11] = '{32'h3FC, 1'b0, 4'd2, 2'b10, 1'b1, 1'b1, 1'b0, 32'h0};

        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        idle_bus();
        do_reset();

        xfer("load_fetch", 32'h0, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 1'b1, 1'b1, 1'b1, 32'h0);
        load_words(4, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            xfer($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].size, vecs[i].trans,
                 vecs[i].rdyin, vecs[i].exp_acc, vecs[i].exp_err, vecs[i].exp_data);
        end

        // Second read accepted in the first read's data cycle
        hsel = 1'b1; haddr = 32'h0; htrans = HTRANS_NONSEQ;
        tick();
        idle_bus();
        chk("b2b_wait_a", hready, 0);
        tick();
        chk("b2b_data_a_hready", hready, 1);
        chk("b2b_data_a", hrdata, 32'h11);
        hsel = 1'b1; haddr = 32'h4; htrans = HTRANS_NONSEQ;
        tick();
        idle_bus();
        chk("b2b_wait_b", hready, 0);
        chk("b2b_wait_b_hrdata", hrdata, 0);
        tick();
        chk("b2b_data_b_hready", hready, 1);
        chk("b2b_data_b", hrdata, 32'h22);
        tick();
        chk("b2b_idle_hrdata", hrdata, 0);

        // Reset while a read is stalled, then a shorter reload hides stale words
        hsel = 1'b1; haddr = 32'h8; htrans = HTRANS_NONSEQ;
        tick();
        idle_bus();
        chk("rw_in_wait", hready, 0);
        do_reset();
        load_words(2, 1'b1, 1'b0, 1'b1);
        xfer("reload_w2", 32'h8, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 1'b1, 1'b1, 1'b0, 32'h0);
        xfer("reload_w1", 32'h4, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 1'b1, 1'b1, 1'b0, 32'h22);

        // Full-depth load without a last marker
        do_reset();
        load_words(DEPTH, 1'b0, 1'b1, 1'b0);
        ld_valid = 1'b1;
        ld_data  = 32'hDEAD_BEEF;
        ld_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("full_ld_ready_low", ld_ready, 0);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        xfer("full_last", 32'h3FC, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 1'b1, 1'b1, 1'b0, model_mem[255]);
        xfer("full_first", 32'h0, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 1'b1, 1'b1, 1'b0, model_mem[0]);

        for (int r = 0; r < 3; r++) begin
            if (r > 0) begin
                do_reset();
                load_words($urandom_range(1, DEPTH - 1), 1'b1, 1'b1, 1'b0);
            end
            for (int t = 0; t < 40; t++) begin
                a = 32'($urandom_range(0, 300)) << 2;
                if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 15) == 0) a[31] = 1'b1;
                wr  = ($urandom_range(0, 7) == 0);
                sz  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd2;
                tr  = 2'($urandom_range(0, 3));
                rdy = ($urandom_range(0, 7) != 0);
                predict(a, wr, sz, tr, rdy, acc, err, data);
                xfer($sformatf("rnd%0d_%0d", r, t), a, wr, sz, tr, rdy, acc, err, data);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_mcu_imem.md
SWITCH_MCU_IMEM -- requirements
Module: switch_mcu_imem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the instruction memory size in 32-bit words (power of 2, 16..4096).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning the data-phase wait cycles per read (0..7).
REQ-003 SHALL have port in_clk, input, 1, the single clock; every flop samples on its rising edge.
REQ-004 SHALL have port in_rst, input, 1, the reset; asynchronous, active-high.
REQ-005 SHALL have port in_ld_valid, input, 1, boot-load word valid.
REQ-006 SHALL have port in_ld_data, input, 32, boot-load instruction word.
REQ-007 SHALL have port in_ld_last, input, 1, marks the final boot-load word.
REQ-008 SHALL have port out_ld_ready, output, 1, load word accepted when high with in_ld_valid.
REQ-009 SHALL have port out_init_done, output, 1, memory loaded and serving fetches; this drives the fetch unit's in_init_done.
REQ-010 SHALL have AHB slave inputs in_hsel (1), in_haddr (32), in_htrans (2), in_hwrite (1), in_hsize (4) and in_hreadyin (1).
REQ-011 SHALL have AHB slave outputs out_hready (1), out_hresp (1; 0 OKAY, 1 ERROR) and out_hrdata (32).

Function
REQ-012 SHALL implement states LOAD, READY, WAIT, ERR1 and ERR2.
REQ-013 LOAD: out_ld_ready=1; each handshake writes in_ld_data to word wr_ptr and increments wr_ptr.
REQ-014 LOAD SHALL exit to READY on a handshake with in_ld_last=1, or on the handshake that writes word DEPTH_WORDS-1.
REQ-015 On the LOAD exit, loaded_cnt SHALL be set to the number of words written, and wr_ptr SHALL not wrap.
REQ-016 out_init_done SHALL be 1 in every state except LOAD; out_ld_ready SHALL be 0 outside LOAD, and load inputs there are ignored.
REQ-017 A transfer SHALL be accepted when in_hsel=1, in_htrans!=0, in_hreadyin=1 and out_hready=1.
REQ-018 Any nonzero htrans SHALL be treated as a transfer, because the fetch unit issues 2'b01.
REQ-019 An accepted transfer SHALL be an error if the state is LOAD, in_hwrite=1, in_hsize!=2, in_haddr[1:0]!=0, or the word index is >= DEPTH_WORDS.
REQ-020 A valid transfer in READY SHALL register the word index and go to WAIT, or give data the next cycle if WAIT_STATES=0.
REQ-021 WAIT SHALL drive out_hready=0 for WAIT_STATES cycles, then 1 cycle of out_hready=1, out_hresp=0 with out_hrdata = mem[index].
REQ-022 If the index is >= loaded_cnt, out_hrdata SHALL be 0.
REQ-023 An error transfer SHALL take the two-cycle response: ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1), then return to the prior idle state (LOAD or READY).
REQ-024 Idle outputs SHALL be out_hready=1, out_hresp=0 and out_hrdata=0.
REQ-025 out_hrdata SHALL be non-zero only in the final data-phase cycle.
REQ-026 A transfer accepted in the last data-phase cycle SHALL be pipelined with no idle bubble (back-to-back).
REQ-027 RAM timing: one synchronous read port; the read SHALL be issued so that data is valid in the final data-phase cycle, and no write SHALL occur outside LOAD.

Reset
REQ-028 in_rst=1 SHALL asynchronously force LOAD, wr_ptr=0, loaded_cnt=0, out_init_done=0, out_ld_ready=0 (1 from the first clock after release), out_hready=1, out_hresp=0, out_hrdata=0.
REQ-029 Reset mid-transfer or mid-load SHALL abandon the operation, and the memory SHALL be reloaded from word 0.
REQ-030 RAM contents SHALL not be reset, and loaded_cnt SHALL gate stale data to zero.

Structure
REQ-031 Package switch_mcu_pkg SHALL hold the HTRANS_IDLE/NONSEQ codes, HSIZE_WORD=2, HRESP_OKAY/ERROR, and the imem state encoding.
REQ-032 The module SHALL instantiate one sub-module, switch_mcu_imem_ram: single-port synchronous RAM (write-enable, address, wdata, registered rdata), DEPTH_WORDS x 32.
REQ-033 The FSM, pointers and AHB response logic SHALL stay in switch_mcu_imem.

Verification
REQ-034 Load 4 words 0x11,0x22,0x33,0x44 (last on 4th) -> out_init_done rises the cycle after; reads at 0x0/0xC return 0x11/0x44 after exactly 1 wait cycle.
REQ-035 After a 4-word load, read haddr=0x10 -> OKAY with hrdata=0; read haddr=0x400 (DEPTH 256) -> ERR1/ERR2 sequence.
REQ-036 Fetch during LOAD, hwrite=1, hsize=0, or haddr=0x2 -> each gets the two-cycle error and the state is unchanged afterwards.
REQ-037 Load 256 words without in_ld_last -> done after word 255; further in_ld_valid is ignored; a read of 0x3FC returns word 255.
REQ-038 Back-to-back reads 0x0, 0x4 (second accepted in the data cycle of the first) -> both complete in 4 cycles total with WAIT_STATES=1.
REQ-039 Assert in_rst during WAIT -> hready=1, hresp=0, init_done=0 immediately; a reload of 2 words gives reads of word 2 = 0.
